// File: rtl/trace_capture_unit.sv
// Retire-trace capture: buffers {pc, instr, wdata} records in a FIFO and replays
// each one as three 32-bit words (pc, instr, wdata) over a valid/ready stream.
module trace_capture_unit #(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         trace_valid,
    input  logic [31:0]                  trace_pc,
    input  logic [31:0]                  trace_instr,
    input  logic [31:0]                  trace_wdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_data,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level,
    output logic [DROP_W-1:0]            drop_count,
    output logic                         overflow,
    input  logic                         clear_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  FULL_LEVEL = CNT_W'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_ONE   = DROP_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        W0,
        W1,
        W2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [95:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [95:0]        hold;
    logic               full;
    logic               not_empty;
    logic               push;
    logic               drop;
    logic               pop;

    // Fullness is judged on the pre-pop level, so a full FIFO drops even while popping.
    assign full      = (fill_level == FULL_LEVEL);
    assign not_empty = (fill_level != '0);
    assign push      = enable && trace_valid && !full;
    assign drop      = enable && trace_valid && full;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_next = state;
        pop        = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        case (state)
            IDLE: begin
                if (not_empty) begin
                    pop        = 1'b1;
                    state_next = W0;
                end
            end
            W0: begin
                out_valid = 1'b1;
                out_data  = hold[95:64];
                if (out_ready) state_next = W1;
            end
            W1: begin
                out_valid = 1'b1;
                out_data  = hold[63:32];
                if (out_ready) state_next = W2;
            end
            W2: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = hold[31:0];
                if (out_ready) begin
                    if (not_empty) begin
                        pop        = 1'b1;
                        state_next = W0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: the storage array is deliberately not reset; the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {trace_pc, trace_instr, trace_wdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            hold       <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
        end
    end

    // A clear coinciding with a drop keeps that drop visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clear_drop) begin
            drop_count <= drop ? DROP_ONE : '0;
            overflow   <= drop;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_trace_capture_unit.sv
// Self-checking bench for trace_capture_unit: directed scenarios plus a randomized
// run against a queue-based reference model of the record stream.
module tb_trace_capture_unit;

    localparam int DEPTH  = 4;
    localparam int DROP_W = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b1;
    logic              trace_valid = 1'b0;
    logic [31:0]       trace_pc = '0;
    logic [31:0]       trace_instr = '0;
    logic [31:0]       trace_wdata = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_data;
    logic              out_last;
    logic [CNT_W-1:0]  fill_level;
    logic [DROP_W-1:0] drop_count;
    logic              overflow;
    logic              clear_drop = 1'b0;

    int checks = 0;
    int errors = 0;

    trace_capture_unit #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .trace_valid(trace_valid),
        .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_wdata(trace_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .fill_level(fill_level), .drop_count(drop_count),
        .overflow(overflow), .clear_drop(clear_drop)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [95:0] r, input int idx);
        case (idx)
            0:       return r[95:64];
            1:       return r[63:32];
            default: return r[31:0];
        endcase
    endfunction

    function automatic logic [95:0] make_rec(input int i);
        return {32'h0000_0100 + 32'(i * 4), 32'h0000_0013 | 32'(i << 7), 32'h1111_1111 * 32'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable      = 1'b1;
        trace_valid = 1'b0;
        clear_drop  = 1'b0;
        trace_pc    = '0;
        trace_instr = '0;
        trace_wdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_rec(input logic [95:0] r);
        trace_valid = 1'b1;
        {trace_pc, trace_instr, trace_wdata} = r;
        tick();
        trace_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h last=%b, want 0/0/0", out_valid, out_data, out_last);
        end
        checks++;
        if (fill_level !== '0 || drop_count !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_counters: fill=%0d drops=%0d ovf=%b, want 0/0/0", fill_level, drop_count, overflow);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_single();
        logic [31:0] exp_w[3];
        exp_w[0] = 32'h0000_0004;
        exp_w[1] = 32'h0050_0093;
        exp_w[2] = 32'h0000_0005;
        out_ready = 1'b1;
        push_rec({exp_w[0], exp_w[1], exp_w[2]});
        checks++;
        if (fill_level !== 3'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: fill=%0d valid=%b, want 1/0", fill_level, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_w[i] || out_last !== (i == 2)) begin
                errors++;
                $display("FAIL single_word%0d: valid=%b data=%h last=%b, want 1/%h/%b",
                         i, out_valid, out_data, out_last, exp_w[i], (i == 2));
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || fill_level !== '0) begin
            errors++;
            $display("FAIL single_done: valid=%b fill=%0d, want 0/0", out_valid, fill_level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [95:0] ra = make_rec(21);
        logic [95:0] rb = make_rec(22);
        out_ready = 1'b0;
        push_rec(ra);
        push_rec(rb);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== ra[95:64]) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b data=%h, want 1/%h", i, out_valid, out_data, ra[95:64]);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== word_of(i < 3 ? ra : rb, i % 3) || out_last !== (i % 3 == 2)) begin
                errors++;
                $display("FAIL b2b_word%0d: valid=%b data=%h last=%b, want 1/%h/%b", i, out_valid,
                         out_data, out_last, word_of(i < 3 ? ra : rb, i % 3), (i % 3 == 2));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: valid=%b, want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 1; i <= 7; i++) push_rec(make_rec(i));
        checks++;
        if (fill_level !== 3'd4 || drop_count !== 4'd2 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_counts: fill=%0d drops=%0d ovf=%b, want 4/2/1", fill_level, drop_count, overflow);
        end
        checks++;
        if (out_data !== word_of(make_rec(1), 0)) begin
            errors++;
            $display("FAIL overflow_head: data=%h, want %h", out_data, word_of(make_rec(1), 0));
        end
    endtask

    task automatic test_clear_coincident();
        clear_drop = 1'b1;
        push_rec(make_rec(8));
        clear_drop = 1'b0;
        checks++;
        if (drop_count !== 4'd1 || overflow !== 1'b1 || fill_level !== 3'd4) begin
            errors++;
            $display("FAIL clear_with_drop: drops=%0d ovf=%b fill=%0d, want 1/1/4", drop_count, overflow, fill_level);
        end
        clear_drop = 1'b1;
        tick();
        clear_drop = 1'b0;
        checks++;
        if (drop_count !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_alone: drops=%0d ovf=%b, want 0/0", drop_count, overflow);
        end
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        for (int r = 1; r <= 5; r++) begin
            for (int w = 0; w < 3; w++) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== word_of(make_rec(r), w) || out_last !== (w == 2)) begin
                    errors++;
                    $display("FAIL drain_r%0d_w%0d: valid=%b data=%h last=%b, want 1/%h/%b", r, w,
                             out_valid, out_data, out_last, word_of(make_rec(r), w), (w == 2));
                end
                tick();
            end
        end
        checks++;
        if (out_valid !== 1'b0 || fill_level !== '0) begin
            errors++;
            $display("FAIL drain_end: valid=%b fill=%0d, want 0/0", out_valid, fill_level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 25; i++) push_rec(make_rec(i + 40));
        checks++;
        if (drop_count !== 4'd15 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drop_saturate: drops=%0d ovf=%b, want 15/1", drop_count, overflow);
        end
    endtask

    task automatic test_enable_gating();
        apply_reset();
        out_ready = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_rec(make_rec(60 + i));
            checks++;
            if (fill_level !== '0 || drop_count !== '0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL enable_gate%0d: fill=%0d drops=%0d valid=%b, want 0/0/0", i, fill_level, drop_count, out_valid);
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL enable_gate_after: valid=%b, want 0", out_valid);
        end
        idle_inputs();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_record();
        logic [95:0] rc = make_rec(77);
        apply_reset();
        out_ready = 1'b1;
        push_rec(make_rec(70));
        push_rec(make_rec(71));
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL midrec_async: valid=%b data=%h last=%b, want 0/0/0", out_valid, out_data, out_last);
        end
        checks++;
        if (fill_level !== '0 || drop_count !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL midrec_counters: fill=%0d drops=%0d ovf=%b, want 0/0/0", fill_level, drop_count, overflow);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrec_quiet%0d: valid=%b, want 0", i, out_valid);
            end
        end
        push_rec(rc);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== rc[95:64]) begin
            errors++;
            $display("FAIL midrec_restart: valid=%b data=%h, want 1/%h", out_valid, out_data, rc[95:64]);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random(input int cycles);
        logic [95:0] q[$];
        logic [95:0] hold = '0;
        logic [95:0] rec;
        bit          hold_v = 1'b0;
        int          idx = 0;
        int          drops = 0;
        bit          ovf = 1'b0;
        int          max_drop = (1 << DROP_W) - 1;
        bit          full, acc, drp, xfer, done, pop;
        logic [31:0] exp_data;
        apply_reset();
        for (int i = 0; i < cycles; i++) begin
            enable      = ($urandom_range(0, 3) != 0);
            trace_valid = ($urandom_range(0, 1) != 0);
            trace_pc    = $urandom;
            trace_instr = $urandom;
            trace_wdata = $urandom;
            out_ready   = (i < cycles / 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clear_drop  = ($urandom_range(0, 15) == 0);
            rec  = {trace_pc, trace_instr, trace_wdata};
            full = (q.size() == DEPTH);
            acc  = enable && trace_valid && !full;
            drp  = enable && trace_valid && full;
            xfer = hold_v && out_ready;
            done = xfer && (idx == 2);
            pop  = (!hold_v || done) && (q.size() != 0);
            if (xfer && idx < 2) idx++;
            if (done) hold_v = 1'b0;
            if (pop) begin
                hold   = q.pop_front();
                hold_v = 1'b1;
                idx    = 0;
            end
            if (acc) q.push_back(rec);
            if (clear_drop) begin
                drops = drp ? 1 : 0;
                ovf   = drp;
            end else if (drp) begin
                ovf = 1'b1;
                if (drops < max_drop) drops++;
            end
            tick();
            exp_data = hold_v ? word_of(hold, idx) : 32'h0;
            checks++;
            if (out_valid !== hold_v || out_data !== exp_data || out_last !== (hold_v && idx == 2)) begin
                errors++;
                $display("FAIL rand_out@%0d: valid=%b data=%h last=%b, want %b/%h/%b", i, out_valid,
                         out_data, out_last, hold_v, exp_data, (hold_v && idx == 2));
            end
            checks++;
            if (int'(fill_level) !== q.size() || int'(drop_count) !== drops || overflow !== ovf) begin
                errors++;
                $display("FAIL rand_cnt@%0d: fill=%0d drops=%0d ovf=%b, want %0d/%0d/%b", i, fill_level,
                         drop_count, overflow, q.size(), drops, ovf);
            end
        end
        idle_inputs();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_clear_coincident();
        test_drain();
        test_saturation();
        test_enable_gating();
        test_reset_mid_record();
        test_random(800);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_capture_unit.md
# trace_capture_unit

Captures the processor's per-instruction retire trace (PC, instruction word, register write-back data) into an on-chip FIFO and replays it as a stream of 32-bit words over a valid/ready port. It is the consuming end of the core's debug/trace signals, so trace can be read out by a host bridge or a hardware checker instead of only through simulation printouts. It sits beside `RISC_V_Processor` and receives the core's trace signals directly.

## Interface
- `DEPTH`, 16: FIFO capacity in trace records; power of two, at least 2.
- `DROP_W`, 16: width of the dropped-record counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: when 0, `trace_valid` is ignored. Ignored records are not counted as drops.
- `trace_valid` in 1: a trace record is presented this cycle.
- `trace_pc` in 32: PC of the retired instruction.
- `trace_instr` in 32: instruction word.
- `trace_wdata` in 32: register write-back data.
- `out_valid` out 1: `out_data` holds a valid word.
- `out_ready` in 1: the consumer accepts the word.
- `out_data` out 32: serialized trace word.
- `out_last` out 1: marks the final word of a record.
- `fill_level` out $clog2(DEPTH+1): number of records in the FIFO. The record held in the output stage is not counted.
- `drop_count` out DROP_W: number of records dropped because the FIFO was full. Saturates at its maximum value.
- `overflow` out 1: sticky; set on any drop.
- `clear_drop` in 1: synchronous clear of `drop_count` and `overflow`.

## Operation
- **Push.** A record `{pc, instr, wdata}` (96 bits) is written into the FIFO when `enable && trace_valid && fill_level != DEPTH`.
  - Fullness is evaluated before any pop in the same cycle.
  - A full FIFO drops the record even if a pop happens that cycle.
- **Drop.** A record is dropped when `enable && trace_valid && fill_level == DEPTH`.
  - `drop_count` increments, saturating at 2^DROP_W−1.
  - `overflow` is set to 1.
- **clear_drop.**
  - Without a drop that cycle: `drop_count` becomes 0 and `overflow` becomes 0.
  - With a drop in the same cycle: `drop_count` becomes 1 and `overflow` becomes 1.
- **Serializer FSM.** States are IDLE, W0, W1, W2.
  - IDLE: if `fill_level != 0`, pop the FIFO head into the output register and go to W0. Otherwise stay in IDLE.
  - W0: `out_data` = pc. On `out_ready`, go to W1.
  - W1: `out_data` = instr. On `out_ready`, go to W2.
  - W2: `out_data` = wdata and `out_last` = 1. On `out_ready`:
    - if the FIFO is non-empty, pop the next record and go to W0 (back-to-back, no IDLE bubble);
    - otherwise go to IDLE.
  - `out_valid` = 1 in W0, W1 and W2, and 0 in IDLE.
  - `out_data` = 0 and `out_last` = 0 in IDLE.
- **Handshake.** A word transfers on any cycle with `out_valid && out_ready`.
  - While `out_valid && !out_ready`, `out_data` and `out_last` must hold stable.
  - `out_valid` never drops without a transfer.
- **Simultaneous push and pop** (FIFO not full): `fill_level` is unchanged. Order is preserved.
- **Draining with enable low.** With `enable` = 0, the serializer keeps draining records already buffered.
- **FIFO pointers.** Read and write pointers wrap modulo DEPTH. `fill_level` is tracked with its own counter, not derived from the pointers.

## Timing
- **Reset.** `rst` asserted asynchronously forces:
  - state = IDLE, `out_valid` = 0, `out_data` = 0, `out_last` = 0;
  - `fill_level` = 0, `drop_count` = 0, `overflow` = 0;
  - both FIFO pointers = 0.
- **Reset mid-record.** Asserting `rst` partway through a record discards it. No partial record is emitted after reset releases.
- **Latency.** A record pushed at edge N (empty FIFO, IDLE) produces `fill_level` = 1 after edge N. It is popped at edge N+1, and `out_valid` is first high in the cycle after edge N+1.
- **Throughput.** With `out_ready` held at 1, records stream at 3 cycles per record with no gaps.
- **Ingress rate.** One record per cycle is accepted. Sustained ingress above 1 record per 3 cycles eventually fills the FIFO.

## Test plan
- **Single record.** After reset, push pc=0x00000004, instr=0x00500093, wdata=0x00000005 with `out_ready`=1.
  - `out_valid` rises 2 cycles after the push.
  - Words 0x4, 0x00500093, 0x5 appear on consecutive cycles, with `out_last` only on the third.
  - `fill_level` returns to 0.
- **Back-pressure.** Push 2 records and hold `out_ready`=0 for 5 cycles.
  - `out_data` holds the first pc stable.
  - Then release `out_ready`: 6 words appear in order with no IDLE gap between records.
- **Overflow.** With DEPTH=4 and `out_ready`=0, push 7 records.
  - The first pops into the output stage, `fill_level` reaches 4, and 2 records are dropped: `drop_count`=2, `overflow`=1.
  - Drain: exactly records 1–5 emerge.
- **Clear coincident with drop.** With the FIFO full, assert `clear_drop` and `trace_valid` in the same cycle.
  - `drop_count`=1 and `overflow`=1.
  - Next cycle, assert `clear_drop` alone: both become 0.
- **Enable gating.** With `enable`=0, pulse `trace_valid` for 3 cycles.
  - `fill_level` stays 0, `drop_count` stays 0, `out_valid` stays 0.
- **Reset mid-record.** After word W1 is accepted, assert `rst` for 1 cycle.
  - `out_valid`=0 immediately (asynchronously), and all counters read 0.
  - Nothing is emitted until a new push.
